// File: rtl/vehicle_lane_scheduler.sv
// vehicle_lane_scheduler
// Round-robin scheduler that lets NUM_LANES vehicle-sensor lanes share one
// serial BCCBC pattern detector (BIKE=0, CAR=1). One lane owns the detector
// at a time for a burst of up to BURST_LEN symbols. The detector is cleared
// between owners, and every detector hit is tagged with the owning lane id.
//
// Ports
//   clk_i, rst_i     clock and synchronous active-high reset
//   lane_valid_i     per-lane symbol available
//   lane_data_i      per-lane symbol
//   lane_ready_o     per-lane accept (one-hot or zero)
//   cfg_overlap_i    overlap mode, sampled only when a lane is granted
//   det_valid_o      detector valid_i
//   det_d_o          detector d_in
//   det_rst_o        detector rst_i
//   det_ol_o         detector moore_OL
//   det_hit_i        detector pattern_detected
//   grant_o          one-hot current owner, zero when idle
//   busy_o           high whenever the scheduler is not idle
//   hit_valid_o      one-cycle pulse per detected pattern
//   hit_lane_o       owning lane of the hit
//   hit_cnt_o        per-lane saturating 8-bit hit counters (HIT_COUNT_EN only)
//
// Optional feature macro: HIT_COUNT_EN
module vehicle_lane_scheduler #(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 2,
    parameter int BURST_LEN = 8,
    parameter int BURST_W   = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_LANES-1:0]   lane_valid_i,
    input  logic [NUM_LANES-1:0]   lane_data_i,
    output logic [NUM_LANES-1:0]   lane_ready_o,
    input  logic                   cfg_overlap_i,
    output logic                   det_valid_o,
    output logic                   det_d_o,
    output logic                   det_rst_o,
    output logic                   det_ol_o,
    input  logic                   det_hit_i,
    output logic [NUM_LANES-1:0]   grant_o,
    output logic                   busy_o,
    output logic                   hit_valid_o,
    output logic [LANE_W-1:0]      hit_lane_o
`ifdef HIT_COUNT_EN
    ,
    output logic [NUM_LANES*8-1:0] hit_cnt_o
`endif
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FLUSH  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [LANE_W-1:0]    rr_q, rr_d;
    logic [LANE_W-1:0]    owner_q, owner_d;
    logic [NUM_LANES-1:0] grant_q, grant_d;
    logic                 ol_q, ol_d;
    logic [BURST_W-1:0]   cnt_q, cnt_d;
    logic                 drain_q, drain_d;
    logic                 det_valid_q, det_valid_d;
    logic                 det_d_q, det_d_d;
    logic                 hit_prev_q, hit_prev_d;
    logic                 hit_valid_q, hit_valid_d;
    logic [LANE_W-1:0]    hit_lane_q, hit_lane_d;

    logic                 pick_found;
    logic [LANE_W-1:0]    pick_idx;
    logic [LANE_W:0]      cand;
    logic [BURST_W-1:0]   cnt_inc;
    logic [LANE_W-1:0]    owner_next;

    // Scan the requests upward from the round-robin pointer with wrap; the
    // first valid lane found wins. cand is one bit wider so the wrap can be
    // done by a single subtraction for any lane count.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            cand = {1'b0, rr_q} + (LANE_W+1)'(i);
            if (cand >= (LANE_W+1)'(NUM_LANES)) begin
                cand = cand - (LANE_W+1)'(NUM_LANES);
            end
            if (!pick_found && lane_valid_i[cand[LANE_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[LANE_W-1:0];
            end
        end
    end

    assign cnt_inc    = cnt_q + BURST_W'(1);
    assign owner_next = (owner_q == LANE_W'(NUM_LANES-1)) ? '0 : owner_q + LANE_W'(1);

    // Next-state logic for the IDLE->FLUSH->STREAM->DRAIN->IDLE sequence.
    // DRAIN lasts two cycles so the hit caused by the last forwarded symbol
    // still lands while the owner is known. Hit detection looks for a rising
    // edge of det_hit_i; the delayed copy is zeroed in FLUSH, where the
    // detector is also being cleared, so a stale hit level from the previous
    // owner cannot produce an edge.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        owner_d     = owner_q;
        grant_d     = grant_q;
        ol_d        = ol_q;
        cnt_d       = cnt_q;
        drain_d     = drain_q;
        det_valid_d = 1'b0;
        det_d_d     = det_d_q;
        hit_prev_d  = det_hit_i;
        hit_valid_d = 1'b0;
        hit_lane_d  = hit_lane_q;

        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d = NUM_LANES'(1) << pick_idx;
                    owner_d = pick_idx;
                    ol_d    = cfg_overlap_i;
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                cnt_d      = '0;
                drain_d    = 1'b0;
                hit_prev_d = 1'b0;
                state_d    = S_STREAM;
            end
            S_STREAM: begin
                if (lane_valid_i[owner_q]) begin
                    det_valid_d = 1'b1;
                    det_d_d     = lane_data_i[owner_q];
                    cnt_d       = cnt_inc;
                    if (cnt_inc == BURST_W'(BURST_LEN)) begin
                        state_d = S_DRAIN;
                    end
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                if (drain_q) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    rr_d    = owner_next;
                end else begin
                    drain_d = 1'b1;
                end
            end
        endcase

        if ((state_q == S_STREAM || state_q == S_DRAIN) && det_hit_i && !hit_prev_q) begin
            hit_valid_d = 1'b1;
            hit_lane_d  = owner_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            owner_q     <= '0;
            grant_q     <= '0;
            ol_q        <= 1'b0;
            cnt_q       <= '0;
            drain_q     <= 1'b0;
            det_valid_q <= 1'b0;
            det_d_q     <= 1'b0;
            hit_prev_q  <= 1'b0;
            hit_valid_q <= 1'b0;
            hit_lane_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            owner_q     <= owner_d;
            grant_q     <= grant_d;
            ol_q        <= ol_d;
            cnt_q       <= cnt_d;
            drain_q     <= drain_d;
            det_valid_q <= det_valid_d;
            det_d_q     <= det_d_d;
            hit_prev_q  <= hit_prev_d;
            hit_valid_q <= hit_valid_d;
            hit_lane_q  <= hit_lane_d;
        end
    end

    assign lane_ready_o = (state_q == S_STREAM) ? grant_q : '0;
    assign det_rst_o    = rst_i | (state_q == S_FLUSH);
    assign det_valid_o  = det_valid_q;
    assign det_d_o      = det_d_q;
    assign det_ol_o     = ol_q;
    assign grant_o      = grant_q;
    assign busy_o       = (state_q != S_IDLE);
    assign hit_valid_o  = hit_valid_q;
    assign hit_lane_o   = hit_lane_q;

`ifdef HIT_COUNT_EN
    // One saturating counter per lane, bumped by each tagged hit pulse.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_hit_cnt
        logic [7:0] lane_cnt_q;
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                lane_cnt_q <= '0;
            end else if (hit_valid_q && hit_lane_q == LANE_W'(k) && lane_cnt_q != 8'hFF) begin
                lane_cnt_q <= lane_cnt_q + 8'd1;
            end
        end
        assign hit_cnt_o[8*k +: 8] = lane_cnt_q;
    end
`endif

endmodule

// File: tb/tb_vehicle_lane_scheduler.sv
// Testbench for vehicle_lane_scheduler. Contains a behavioural BCCBC detector,
// per-lane symbol sources, and a monitor. The monitor pops expected grants,
// forwarded symbols and hit tags from scoreboard queues.
module tb_vehicle_lane_scheduler;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 2;
    localparam int BURST_LEN = 8;
    localparam int BURST_W   = 4;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic [NUM_LANES-1:0] lane_valid_i;
    logic [NUM_LANES-1:0] lane_data_i;
    logic [NUM_LANES-1:0] lane_ready_o;
    logic                 cfg_overlap_i;
    logic                 det_valid_o, det_d_o, det_rst_o, det_ol_o, det_hit_i;
    logic [NUM_LANES-1:0] grant_o;
    logic                 busy_o, hit_valid_o;
    logic [LANE_W-1:0]    hit_lane_o;
`ifdef HIT_COUNT_EN
    logic [NUM_LANES*8-1:0] hit_cnt_o;
`endif

    vehicle_lane_scheduler #(
        .NUM_LANES(NUM_LANES), .LANE_W(LANE_W), .BURST_LEN(BURST_LEN), .BURST_W(BURST_W)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .lane_valid_i(lane_valid_i), .lane_data_i(lane_data_i), .lane_ready_o(lane_ready_o),
        .cfg_overlap_i(cfg_overlap_i),
        .det_valid_o(det_valid_o), .det_d_o(det_d_o), .det_rst_o(det_rst_o),
        .det_ol_o(det_ol_o), .det_hit_i(det_hit_i),
        .grant_o(grant_o), .busy_o(busy_o),
        .hit_valid_o(hit_valid_o), .hit_lane_o(hit_lane_o)
`ifdef HIT_COUNT_EN
        , .hit_cnt_o(hit_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int   lane;
        logic ol;
        int   burst;
    } grantExp_t;

    int        errors = 0;
    int        checks = 0;
    bit        srcQ [NUM_LANES][$];
    bit        expSym[$];
    int        expHit[$];
    grantExp_t expGrant[$];

    // Behavioural Moore detector for 0,1,1,0,1. Its hit output follows the
    // symbol that completes the pattern and holds until the next symbol.
    // In non-overlapping mode, a detection restarts the symbol count.
    logic [4:0] dHist;
    int         dN;
    logic       dHit;
    logic       dMatch;
    assign dMatch    = (dN >= 4) && ({dHist[3:0], det_d_o} == 5'b01101);
    assign det_hit_i = dHit;

    always @(posedge clk_i) begin
        if (det_rst_o) begin
            dHist <= '0;
            dN    <= 0;
            dHit  <= 1'b0;
        end else if (det_valid_o) begin
            dHist <= {dHist[3:0], det_d_o};
            dHit  <= dMatch;
            dN    <= (dMatch && !det_ol_o) ? 0 : ((dN < 5) ? dN + 1 : 5);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic noteUnexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got %0d expected nothing at %0t", name, act, $time);
    endtask

    // Queue n symbols on a lane, taken MSB-first from pat.
    task automatic applyStimulus(input int lane, input logic [7:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            srcQ[lane].push_back(pat[7-i]);
        end
    endtask

    task automatic expectGrant(input int lane, input logic ol, input int burst);
        grantExp_t e;
        e.lane  = lane;
        e.ol    = ol;
        e.burst = burst;
        expGrant.push_back(e);
    endtask

    function automatic bit srcEmpty();
        for (int k = 0; k < NUM_LANES; k++) begin
            if (srcQ[k].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Lane sources: on each falling edge, retire the symbol accepted at the
    // previous rising edge, present the next one, and record the transfer
    // that the coming rising edge will perform as an expected detector symbol.
    initial begin : driver
        logic [NUM_LANES-1:0] pend;
        lane_valid_i = '0;
        lane_data_i  = '0;
        pend         = '0;
        forever begin
            @(negedge clk_i);
            for (int k = 0; k < NUM_LANES; k++) begin
                if (pend[k] && srcQ[k].size() != 0) void'(srcQ[k].pop_front());
            end
            for (int k = 0; k < NUM_LANES; k++) begin
                lane_valid_i[k] = (srcQ[k].size() != 0);
                lane_data_i[k]  = (srcQ[k].size() != 0) ? srcQ[k][0] : 1'b0;
            end
            pend = rst_i ? '0 : (lane_valid_i & lane_ready_o);
            for (int k = 0; k < NUM_LANES; k++) begin
                if (pend[k]) expSym.push_back(lane_data_i[k]);
            end
        end
    end

    // Monitor: samples 1 time unit after each rising edge and checks grants,
    // FLUSH behaviour, forwarded symbols, burst lengths and hit tags.
    initial begin : monitor
        logic [NUM_LANES-1:0] prevGrant;
        int                   burstCnt;
        int                   curBurst;
        bit                   have;
        bit                   flushNext;
        grantExp_t            e;
        prevGrant = '0;
        burstCnt  = 0;
        curBurst  = 0;
        have      = 1'b0;
        flushNext = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (rst_i) begin
                prevGrant = '0;
                have      = 1'b0;
                flushNext = 1'b0;
            end else begin
                checkOutput("readyOwner", 32'(lane_ready_o & ~grant_o), 32'd0);
                checkOutput("busyVsGrant", 32'(busy_o), 32'(grant_o != '0));
                if (flushNext) begin
                    checkOutput("flushOneCycle", 32'(det_rst_o), 32'd0);
                    flushNext = 1'b0;
                end
                if (det_valid_o) begin
                    burstCnt++;
                    if (expSym.size() == 0) noteUnexpected("detSymbol", 32'(det_d_o));
                    else checkOutput("detSymbol", 32'(det_d_o), 32'(expSym.pop_front()));
                end
                if (hit_valid_o) begin
                    if (expHit.size() == 0) noteUnexpected("hitLane", 32'(hit_lane_o));
                    else checkOutput("hitLane", 32'(hit_lane_o), 32'(expHit.pop_front()));
                end
                if (prevGrant == '0 && grant_o != '0) begin
                    if (expGrant.size() == 0) begin
                        noteUnexpected("grant", 32'(grant_o));
                        have = 1'b0;
                    end else begin
                        e = expGrant.pop_front();
                        checkOutput("grant", 32'(grant_o), 32'd1 << e.lane);
                        checkOutput("grantOl", 32'(det_ol_o), 32'(e.ol));
                        curBurst = e.burst;
                        have     = 1'b1;
                    end
                    checkOutput("flushDetRst", 32'(det_rst_o), 32'd1);
                    checkOutput("flushReady", 32'(lane_ready_o), 32'd0);
                    burstCnt  = 0;
                    flushNext = 1'b1;
                end
                if (prevGrant != '0 && grant_o == '0 && have) begin
                    checkOutput("burstLen", 32'(burstCnt), 32'(curBurst));
                    have = 1'b0;
                end
                prevGrant = grant_o;
            end
        end
    end

    // Hold reset for n cycles and check every output at its reset value.
    task automatic doReset(input int n);
        rst_i = 1'b1;
        repeat (n) begin
            @(posedge clk_i);
            #2;
            checkOutput("rstGrant", 32'(grant_o), 32'd0);
            checkOutput("rstReady", 32'(lane_ready_o), 32'd0);
            checkOutput("rstDetValid", 32'(det_valid_o), 32'd0);
            checkOutput("rstDetD", 32'(det_d_o), 32'd0);
            checkOutput("rstDetOl", 32'(det_ol_o), 32'd0);
            checkOutput("rstDetRst", 32'(det_rst_o), 32'd1);
            checkOutput("rstHitValid", 32'(hit_valid_o), 32'd0);
            checkOutput("rstHitLane", 32'(hit_lane_o), 32'd0);
            checkOutput("rstBusy", 32'(busy_o), 32'd0);
        end
        rst_i = 1'b0;
    endtask

    task automatic waitGrant();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk_i);
            #2;
            if (grant_o != '0) got = 1'b1;
        end
        checkOutput("grantTimeout", 32'(got), 32'd1);
    endtask

    // Wait until all sources are empty and the scheduler has stayed idle for
    // a few cycles, then require every scoreboard queue to be drained.
    task automatic waitIdle(input string tag);
        int quiet;
        quiet = 0;
        for (int i = 0; i < 3000 && quiet < 4; i++) begin
            @(posedge clk_i);
            #2;
            if (!busy_o && srcEmpty()) quiet++;
            else quiet = 0;
        end
        checkOutput({tag, "_idleTimeout"}, 32'(quiet >= 4), 32'd1);
        checkOutput({tag, "_missingHits"}, 32'(expHit.size()), 32'd0);
        checkOutput({tag, "_missingGrants"}, 32'(expGrant.size()), 32'd0);
        checkOutput({tag, "_missingSymbols"}, 32'(expSym.size()), 32'd0);
    endtask

    initial begin : main
        rst_i         = 1'b1;
        cfg_overlap_i = 1'b0;
        doReset(2);

        // Reset in the middle of a burst abandons it without a hit.
        $display("[TB] reset mid-stream");
        applyStimulus(2, 8'b0110_1111, 8);
        expectGrant(2, 1'b0, 8);
        waitGrant();
        repeat (4) @(posedge clk_i);
        #2;
        doReset(3);
        srcQ[2].delete();
        waitIdle("midReset");

        // Lane 2 alone, non-overlapping, one BCCBC.
        $display("[TB] single lane pattern");
        doReset(2);
        applyStimulus(2, 8'b0110_1000, 5);
        expectGrant(2, 1'b0, 5);
        expHit.push_back(2);
        waitIdle("lane2");

        // All lanes busy: strict rotation, full bursts, wrap back to lane 0.
        $display("[TB] round robin");
        doReset(2);
        applyStimulus(0, 8'h00, 8);
        applyStimulus(0, 8'h00, 8);
        applyStimulus(1, 8'b0110_1000, 8);
        applyStimulus(2, 8'h00, 8);
        applyStimulus(3, 8'h00, 8);
        expectGrant(0, 1'b0, 8);
        expectGrant(1, 1'b0, 8);
        expectGrant(2, 1'b0, 8);
        expectGrant(3, 1'b0, 8);
        expectGrant(0, 1'b0, 8);
        expHit.push_back(1);
        waitIdle("roundRobin");

        // Partial pattern split across owners must not produce a hit.
        $display("[TB] split pattern");
        doReset(2);
        applyStimulus(1, 8'b0110_0000, 3);
        applyStimulus(3, 8'b0100_0000, 2);
        expectGrant(1, 1'b0, 3);
        expectGrant(3, 1'b0, 2);
        waitIdle("split");

        // Overlap mode: two hits, the second on the final symbol of the burst.
        $display("[TB] overlap modes");
        doReset(2);
        cfg_overlap_i = 1'b1;
        applyStimulus(0, 8'b0110_1101, 8);
        expectGrant(0, 1'b1, 8);
        expHit.push_back(0);
        expHit.push_back(0);
        waitIdle("overlap");
        cfg_overlap_i = 1'b0;
        applyStimulus(0, 8'b0110_1101, 8);
        expectGrant(0, 1'b0, 8);
        expHit.push_back(0);
        waitGrant();
        repeat (3) @(posedge clk_i);
        #2;
        cfg_overlap_i = 1'b1;
        waitIdle("nonOverlap");
        cfg_overlap_i = 1'b0;

`ifdef HIT_COUNT_EN
        // 300 hits on lane 3 saturate its counter and leave the others at 0.
        $display("[TB] hit counter saturation");
        doReset(2);
        cfg_overlap_i = 1'b1;
        for (int g = 0; g < 150; g++) begin
            applyStimulus(3, 8'b0110_1101, 8);
            expectGrant(3, 1'b1, 8);
            expHit.push_back(3);
            expHit.push_back(3);
        end
        waitIdle("hitCount");
        checkOutput("hitCnt3", 32'(hit_cnt_o[31:24]), 32'd255);
        checkOutput("hitCntOthers", 32'(hit_cnt_o[23:0]), 32'd0);
        cfg_overlap_i = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
